// File: rtl/fetch_unit_pkg.sv
// Shared fetch/branch definitions: next-PC select codes,
// branch comparator codes and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam logic [2:0] COMP_EQ  = 3'b000;
    localparam logic [2:0] COMP_NE  = 3'b001;
    localparam logic [2:0] COMP_LT  = 3'b100;
    localparam logic [2:0] COMP_GE  = 3'b101;
    localparam logic [2:0] COMP_LTU = 3'b110;
    localparam logic [2:0] COMP_GEU = 3'b111;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_HOLD,
        FS_FAULT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC mux: PC+4 (also for pcsrc=11), branch/JAL target, or JALR
// target with bit0 cleared. Ports: pc, pcsrc, pc_target, jalr_target
// in; next_pc, misaligned (next_pc[1:0] != 0) out.
module next_pc_sel
    import fetch_unit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] pc,
    input  logic [1:0]   pcsrc,
    input  logic [N-1:0] pc_target,
    input  logic [N-1:0] jalr_target,
    output logic [N-1:0] next_pc,
    output logic         misaligned
);

    always_comb begin
        next_pc = pc + N'(4);
        unique case (1'b1)
            (pcsrc == PCSRC_TARGET): next_pc = pc_target;
            (pcsrc == PCSRC_JALR):   next_pc = {jalr_target[N-1:1], 1'b0};
            default:                 next_pc = pc + N'(4);
        endcase
        misaligned = |next_pc[1:0];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, holds the fetched
// instruction until decode accepts it, then picks the next PC.
// Ports: clk, rst_n; pcsrc/pc_target/jalr_target (next-PC select,
// sampled only on the decode transfer); imem_req_* request handshake;
// imem_rsp_* response; inst_valid/inst_ready/inst/inst_pc to decode;
// misalign sticky fault flag.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int         N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   pcsrc,
    input  logic [N-1:0] pc_target,
    input  logic [N-1:0] jalr_target,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [N-1:0] imem_req_addr,
    input  logic         imem_rsp_valid,
    input  logic [31:0]  imem_rsp_data,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [31:0]  inst,
    output logic [N-1:0] inst_pc,
    output logic         misalign
);

    fetch_state_t state, state_nx;
    logic [N-1:0] pc;
    logic [N-1:0] next_pc;
    logic         misaligned;
    logic         xfer;
    logic         rsp_take;

    next_pc_sel #(.N(N)) u_next_pc_sel (
        .pc          (pc),
        .pcsrc       (pcsrc),
        .pc_target   (pc_target),
        .jalr_target (jalr_target),
        .next_pc     (next_pc),
        .misaligned  (misaligned)
    );

    assign imem_req_addr = pc;

    always_comb begin
        state_nx       = state;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        misalign       = 1'b0;
        xfer           = 1'b0;
        rsp_take       = 1'b0;
        unique case (state)
            FS_IDLE: state_nx = FS_REQ;
            FS_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) state_nx = FS_WAIT;
            end
            FS_WAIT: begin
                if (imem_rsp_valid) begin
                    rsp_take = 1'b1;
                    state_nx = FS_HOLD;
                end
            end
            FS_HOLD: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    xfer     = 1'b1;
                    state_nx = misaligned ? FS_FAULT : FS_REQ;
                end
            end
            FS_FAULT: misalign = 1'b1;
            default:  state_nx = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FS_IDLE;
        else        state <= state_nx;
    end

    // A misaligned target leaves pc at the faulting instruction's PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    pc <= RESET_PC;
        else if (xfer && !misaligned)  pc <= next_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst    <= '0;
            inst_pc <= '0;
        end else if (rsp_take) begin
            inst    <= imem_rsp_data;
            inst_pc <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of next-PC vectors driven
// through a responsive imem model, plus reset/backpressure sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pcsrc;
    logic [31:0] pc_target;
    logic [31:0] jalr_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misalign;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pcsrc          (pcsrc),
        .pc_target      (pc_target),
        .jalr_target    (jalr_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .misalign       (misalign)
    );

    typedef struct {
        logic [1:0]  src;
        logic [31:0] tgt;
        logic [31:0] jtgt;
        logic [31:0] pc;
        logic [31:0] nxt;
        logic        fault;
    } vec_t;

    vec_t        vt[10];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        mem_on = 1'b1;
    logic        force_rsp = 1'b0;
    logic [31:0] reqlog[$];

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return 32'h0000_0013 ^ (a << 4);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: note a request handshake, answer it one cycle later.
    task automatic step();
        logic        hs;
        logic [31:0] a;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_req_addr;
        @(posedge clk);
        if (hs) reqlog.push_back(a);
        @(negedge clk);
        cyc++;
        if (force_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (hs && mem_on) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mdata(a);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic wait_hold(output int at);
        int k = 0;
        while (!inst_valid && k < 40) begin
            step();
            k++;
        end
        chk("hold_reached", 32'(inst_valid), 32'd1);
        at = cyc;
    endtask

    task automatic wait_req();
        int k = 0;
        while (!imem_req_valid && k < 40) begin
            step();
            k++;
        end
        chk("req_reached", 32'(imem_req_valid), 32'd1);
    endtask

    initial begin
        int at;
        int last;
        int n0;

        vt[0] = '{2'b00, 32'h0,         32'h0,   32'h0,         32'h4,         1'b0};
        vt[1] = '{2'b00, 32'h0,         32'h0,   32'h4,         32'h8,         1'b0};
        vt[2] = '{2'b11, 32'h0,         32'h0,   32'h8,         32'hC,         1'b0};
        vt[3] = '{2'b01, 32'h10,        32'h0,   32'hC,         32'h10,        1'b0};
        vt[4] = '{2'b01, 32'h40,        32'h0,   32'h10,        32'h40,        1'b0};
        vt[5] = '{2'b10, 32'h0,         32'h101, 32'h40,        32'h100,       1'b0};
        vt[6] = '{2'b01, 32'hFFFF_FFFC, 32'h0,   32'h100,       32'hFFFF_FFFC, 1'b0};
        vt[7] = '{2'b00, 32'h0,         32'h0,   32'hFFFF_FFFC, 32'h0,         1'b0};
        vt[8] = '{2'b10, 32'h0,         32'h81,  32'h0,         32'h80,        1'b0};
        vt[9] = '{2'b10, 32'h0,         32'h102, 32'h80,        32'h80,        1'b1};

        rst_n          = 1'b0;
        pcsrc          = 2'b00;
        pc_target      = '0;
        jalr_target    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b1;
        step();
        step();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);

        rst_n = 1'b1;
        chk("idle_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);

        last = 0;
        for (int i = 0; i < 10; i++) begin
            wait_hold(at);
            chk($sformatf("v%0d_inst_pc", i), inst_pc, vt[i].pc);
            chk($sformatf("v%0d_inst", i), inst, mdata(vt[i].pc));
            if (i > 0) chk($sformatf("v%0d_period", i), 32'(at - last), 32'd3);
            last        = at;
            pcsrc       = vt[i].src;
            pc_target   = vt[i].tgt;
            jalr_target = vt[i].jtgt;
            step();
            pcsrc       = 2'b10;
            pc_target   = 32'h2;
            jalr_target = 32'h3;
            if (!vt[i].fault) begin
                wait_req();
                chk($sformatf("v%0d_next_addr", i), imem_req_addr, vt[i].nxt);
            end else begin
                n0 = reqlog.size();
                chk($sformatf("v%0d_misalign", i), 32'(misalign), 32'd1);
                chk($sformatf("v%0d_pc_kept", i), imem_req_addr, vt[i].nxt);
                for (int k = 0; k < 6; k++) begin
                    step();
                    chk("fault_req_valid", 32'(imem_req_valid), 32'd0);
                    chk("fault_inst_valid", 32'(inst_valid), 32'd0);
                    chk("fault_sticky", 32'(misalign), 32'd1);
                end
                chk("fault_no_req", 32'(reqlog.size() - n0), 32'd0);
            end
        end

        // Backpressure on both handshakes.
        rst_n = 1'b0;
        step();
        chk("rst_clears_fault", 32'(misalign), 32'd0);
        pcsrc          = 2'b00;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        rst_n          = 1'b1;
        step();
        n0 = reqlog.size();
        for (int k = 0; k < 4; k++) begin
            chk("bp_req_valid", 32'(imem_req_valid), 32'd1);
            chk("bp_req_addr", imem_req_addr, 32'h0);
            step();
        end
        imem_req_ready = 1'b1;
        wait_hold(at);
        for (int k = 0; k < 3; k++) begin
            chk("bp_inst_valid", 32'(inst_valid), 32'd1);
            chk("bp_inst", inst, mdata(32'h0));
            chk("bp_inst_pc", inst_pc, 32'h0);
            if (k < 2) step();
        end
        inst_ready = 1'b1;
        step();
        chk("bp_no_dup", 32'(inst_valid), 32'd0);
        chk("bp_next_addr", imem_req_addr, 32'h4);
        chk("bp_one_req", 32'(reqlog.size() - n0), 32'd1);
        chk("bp_req_log", reqlog[n0], 32'h0);

        // Reset while a response is outstanding; late response ignored.
        mem_on = 1'b0;
        step();
        chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_inst", inst, 32'h0);
        chk("mid_rst_addr", imem_req_addr, 32'h0);
        step();
        rst_n          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        force_rsp      = 1'b1;
        step();
        step();
        chk("late_rsp_inst_valid", 32'(inst_valid), 32'd0);
        chk("late_rsp_inst", inst, 32'h0);
        chk("late_rsp_addr", imem_req_addr, 32'h0);
        force_rsp      = 1'b0;
        mem_on         = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        wait_hold(at);
        chk("rerun_inst", inst, mdata(32'h0));
        chk("rerun_inst_pc", inst_pc, 32'h0);

        // Misaligned branch target also faults.
        pcsrc     = 2'b01;
        pc_target = 32'h22;
        step();
        chk("tgt_misalign", 32'(misalign), 32'd1);
        chk("tgt_req_valid", 32'(imem_req_valid), 32'd0);
        chk("tgt_pc_kept", imem_req_addr, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("tgt_rst_clear", 32'(misalign), 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter N SHALL default to 32; it is the PC and target width.
REQ-002 Parameter RESET_PC SHALL default to 32'h0000_0000; it is the first fetch address.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 pcsrc  in  2  SHALL be the next-PC select from the branch comparator: 00 PC+4, 01 pc_target, 10 jalr_target, 11 treated as PC+4.
REQ-006 pc_target  in  N  SHALL be the branch/JAL target (PC+imm).
REQ-007 jalr_target  in  N  SHALL be the JALR target (rs1+imm, bit0 not yet cleared).
REQ-008 imem_req_valid  out  1 / imem_req_ready  in  1 / imem_req_addr  out  N  SHALL form the instruction-memory request handshake.
REQ-009 imem_rsp_valid  in  1 / imem_rsp_data  in  32  SHALL carry the instruction-memory response.
REQ-010 inst_valid  out  1 / inst_ready  in  1 / inst  out  32 / inst_pc  out  N  SHALL form the handshake to decode/execute.
REQ-011 misalign  out  1  SHALL flag a misaligned next PC (sticky fault).

Function
REQ-012 The FSM SHALL have states IDLE, REQ, WAIT, HOLD, FAULT.
REQ-013 IDLE -> REQ unconditionally on the next edge.
REQ-014 In REQ: imem_req_valid=1, imem_req_addr=pc; -> WAIT when imem_req_ready=1, else stay.
REQ-015 In WAIT: imem_req_valid=0; on imem_rsp_valid=1, latch imem_rsp_data into inst, pc into inst_pc, -> HOLD; imem_rsp_valid outside WAIT SHALL be ignored.
REQ-016 In HOLD: inst_valid=1, inst/inst_pc stable until the transfer (inst_valid & inst_ready).
REQ-017 On transfer, pcsrc, pc_target and jalr_target SHALL be sampled in that same cycle to form next_pc; they are don't-care in all other cycles.
REQ-018 next_pc: PC+4 modulo 2^N (wraps at 0xFFFF_FFFC -> 0x0000_0000); pc_target unchanged; jalr_target with bit0 cleared.
REQ-019 If next_pc[1:0] != 0: pc SHALL NOT update, -> FAULT; else pc <= next_pc, -> REQ.
REQ-020 FAULT SHALL be sticky until reset: misalign=1, imem_req_valid=0, inst_valid=0.
REQ-021 Minimum throughput SHALL be one instruction per 3 cycles (REQ, WAIT, HOLD with ready/valid high throughout).
REQ-022 Outside REQ, imem_req_valid SHALL be 0; outside HOLD, inst_valid SHALL be 0.

Reset
REQ-023 While rst_n=0: state=IDLE, pc=RESET_PC, inst=0, inst_pc=0, imem_req_valid=0, inst_valid=0, misalign=0.
REQ-024 Reset asserted mid-operation (any state, including an outstanding WAIT) SHALL abandon it immediately; a late imem_rsp_valid after release SHALL be ignored (state is IDLE/REQ).
REQ-025 imem_req_valid SHALL first assert in the second cycle after rst_n rises (IDLE occupies the first).

Structure
REQ-026 PCSrc encodings (PCSRC_PLUS4=00, PCSRC_TARGET=01, PCSRC_JALR=10) and the fetch-state enum SHALL live in the shared defs file alongside the COMP_* codes.
REQ-027 One combinational sub-module next_pc_sel (pc, pcsrc, pc_target, jalr_target -> next_pc, misaligned) SHALL be instantiated; the FSM and registers stay in fetch_unit.

Verification
REQ-028 Reset release, RESET_PC=0, req_ready=1, rsp 1 cycle later with 32'h0000_0013, inst_ready=1, pcsrc=00 -> requests at 0x0, 0x4, 0x8; inst_pc matches; one instruction per 3 cycles.
REQ-029 In HOLD, inst_pc=0x10, pcsrc=01, pc_target=0x40 -> next imem_req_addr=0x40.
REQ-030 pcsrc=10, jalr_target=0x0000_0101 -> imem_req_addr=0x100; jalr_target=0x102 -> misalign=1, FAULT, no further requests until reset.
REQ-031 Backpressure: imem_req_ready low 4 cycles, inst_ready low 3 cycles -> addr/inst/inst_pc stable throughout, no duplicate or lost instruction.
REQ-032 pc=0xFFFF_FFFC, pcsrc=00 -> next request at 0x0000_0000.
REQ-033 rst_n pulsed low during WAIT, imem_rsp_valid arriving after release -> response ignored, first request at RESET_PC.
